// File: rtl/lead_pattern_gen_pkg.sv
// lead_pattern_gen_pkg: shared byte width, run limit and FSM state type for the leading-pattern generator
package lead_pattern_gen_pkg;
  localparam int BYTE_W = 8;
  localparam int LEAD_MAX = 32;
  typedef enum logic [1:0] {IDLE, GEN, DONE} lead_gen_state_t;
endpackage

// File: rtl/lead_pattern_gen_byte.sv
// lead_pattern_gen_byte: combinational byte of k (0..8) leading fill bits then complement bits (k, fill -> pat)
module lead_pattern_gen_byte (
  input  logic [3:0] k,
  input  logic       fill,
  output logic [7:0] pat
);
  logic [7:0] tail;
  assign tail = 8'hff >> k;
  assign pat = fill ? ~tail : tail;
endmodule

// File: rtl/lead_pattern_gen.sv
// lead_pattern_gen: byte-serial inverse CLZ/CLO (clk, async active-low rst, flush_i, start_i/cnt_en_i/count_i in; ready_o/valid_o/val_o/ovf_o out)
module lead_pattern_gen
  import lead_pattern_gen_pkg::*;
#(
  parameter int BYTES = 4,
  parameter int CNT_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  start_i,
  input  logic                  cnt_en_i,
  input  logic [CNT_W-1:0]      count_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [BYTE_W*BYTES-1:0] val_o,
  output logic                  ovf_o
);
  localparam int IW = $clog2(BYTES);
  localparam logic [IW-1:0] LAST = IW'(BYTES - 1);
  localparam logic [CNT_W-1:0] NMAX = CNT_W'(BYTE_W * BYTES);
  localparam logic signed [CNT_W:0] EIGHT = (CNT_W+1)'(BYTE_W);
  lead_gen_state_t state;
  logic [IW-1:0] idx;
  logic [CNT_W-1:0] n;
  logic [CNT_W-1:0] off;
  logic fill;
  logic signed [CNT_W:0] diff;
  logic [3:0] k;
  logic [7:0] pat;
  assign off = CNT_W'(LAST - idx) << 3;
  assign diff = $signed({1'b0, n}) - $signed({1'b0, off});
  assign k = diff[CNT_W] ? 4'd0 : (diff > EIGHT ? 4'd8 : diff[3:0]);
  assign ready_o = state == IDLE;
  lead_pattern_gen_byte u_byte (.k(k), .fill(fill), .pat(pat));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx <= LAST;
      n <= '0;
      fill <= 1'b0;
      val_o <= '0;
      valid_o <= 1'b0;
      ovf_o <= 1'b0;
    end else if (flush_i) begin
      state <= IDLE;
      idx <= LAST;
      val_o <= '0;
      valid_o <= 1'b0;
      ovf_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          fill <= cnt_en_i;
          n <= count_i > NMAX ? NMAX : count_i;
          ovf_o <= count_i > NMAX;
          idx <= LAST;
          val_o <= '0;
          state <= GEN;
        end
        GEN: begin
          val_o[idx*BYTE_W +: BYTE_W] <= pat;
          if (idx == '0) begin
            state <= DONE;
            valid_o <= 1'b1;
          end else idx <= idx - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lead_pattern_gen.sv
// tb_lead_pattern_gen: directed self-checking bench with a per-cycle reference model of lead_pattern_gen
module tb_lead_pattern_gen;
  logic clk = 0, rst = 0, flush_i = 0, start_i = 0, cnt_en_i = 0;
  logic [5:0] count_i = '0;
  logic ready_o, valid_o, ovf_o;
  logic [31:0] val_o;
  int checks = 0, failures = 0;

  lead_pattern_gen dut (.clk(clk), .rst(rst), .flush_i(flush_i), .start_i(start_i),
    .cnt_en_i(cnt_en_i), .count_i(count_i), .ready_o(ready_o), .valid_o(valid_o),
    .val_o(val_o), .ovf_o(ovf_o));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Bit i from the top is the fill bit iff i < n.
  function automatic logic [31:0] model_word(input logic f, input int n);
    logic [31:0] w;
    for (int i = 0; i < 32; i++) w[31-i] = (i < n) ? f : ~f;
    return w;
  endfunction

  function automatic int lead_count(input logic [31:0] w, input logic f);
    int c = 0;
    for (int i = 31; i >= 0; i--) begin
      if (w[i] != f) break;
      c++;
    end
    return c;
  endfunction

  // Reference model: cycles elapsed since an accepted request (-1 = idle).
  initial begin
    int phase = -1;
    logic [31:0] exp_word = '0, exp_val = '0;
    logic exp_ovf = 0;
    forever begin
      @(negedge clk);
      if (!rst || flush_i) begin
        phase = -1;
        exp_val = '0;
        exp_ovf = 0;
      end else if (phase < 0) begin
        if (start_i) begin
          phase = 0;
          exp_word = model_word(cnt_en_i, count_i > 32 ? 32 : int'(count_i));
          exp_ovf = count_i > 32;
          exp_val = '0;
        end
      end else begin
        phase++;
        if (phase == 4) exp_val = exp_word;
        if (phase == 5) phase = -1;
      end
      chk("ready", {31'b0, ready_o}, {31'b0, phase < 0});
      chk("valid", {31'b0, valid_o}, {31'b0, phase == 4});
      chk("ovf", {31'b0, ovf_o}, {31'b0, exp_ovf});
      if (phase <= 0 || phase == 4) chk("val", val_o, exp_val);
    end
  end

  task automatic go(input logic f, input logic [5:0] c);
    @(negedge clk); #1;
    cnt_en_i = f;
    count_i = c;
    start_i = 1;
    @(negedge clk); #1;
    start_i = 0;
  endtask

  task automatic wait_valid();
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!valid_o && i < 12);
    chk("valid_seen", {31'b0, valid_o}, 32'd1);
  endtask

  task automatic run(input logic f, input logic [5:0] c, input logic [31:0] ew, input logic eo, input string nm);
    go(f, c);
    wait_valid();
    chk({nm, "_val"}, val_o, ew);
    chk({nm, "_ovf"}, {31'b0, ovf_o}, {31'b0, eo});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, ready_o}, 32'd1);
    chk("rst_val", val_o, 32'h0);
    #1 rst = 1;
    chk("model_pin12", model_word(1, 12), 32'hFFF00000);
    chk("model_pin5", model_word(0, 5), 32'h07FFFFFF);
    run(1, 6'd12, 32'hFFF00000, 0, "ones12");
    run(0, 6'd5, 32'h07FFFFFF, 0, "zeros5");
    run(0, 6'd0, 32'hFFFFFFFF, 0, "zeros0");
    run(1, 6'd0, 32'h00000000, 0, "ones0");
    run(0, 6'd32, 32'h00000000, 0, "zeros32");
    run(0, 6'd40, 32'h00000000, 1, "zeros40");
    run(1, 6'd63, 32'hFFFFFFFF, 1, "ones63");
    go(1, 6'd12);
    @(negedge clk); #1;
    count_i = 6'd3;
    start_i = 1;
    @(negedge clk); #1;
    start_i = 0;
    wait_valid();
    chk("busy_start_val", val_o, 32'hFFF00000);
    repeat (3) @(negedge clk);
    go(1, 6'd20);
    @(negedge clk);
    @(negedge clk); #1;
    flush_i = 1;
    @(negedge clk);
    chk("flush_val", val_o, 32'h0);
    chk("flush_ready", {31'b0, ready_o}, 32'd1);
    #1 flush_i = 0;
    run(1, 6'd8, 32'hFF000000, 0, "after_flush");
    go(1, 6'd40);
    @(posedge clk);
    @(posedge clk); #2;
    rst = 0;
    #1;
    chk("arst_val", val_o, 32'h0);
    chk("arst_ovf", {31'b0, ovf_o}, 32'd0);
    chk("arst_ready", {31'b0, ready_o}, 32'd1);
    chk("arst_valid", {31'b0, valid_o}, 32'd0);
    @(negedge clk); #1;
    rst = 1;
    repeat (8) @(negedge clk);
    for (int f = 0; f < 2; f++)
      for (int n = 0; n <= 32; n++) begin
        go(f[0], 6'(n));
        wait_valid();
        chk("sweep_count", lead_count(val_o, f[0]), n);
      end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
